// File: rtl/dense_layer_sequencer_pkg.sv
// Shared fixed-point definitions for the Q6.10 inference datapath.
package data16_10;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned DATA_NFRAC = 10;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    // Sequencer state encoding (values live as localparams in the sequencer)
    typedef logic [2:0] state_t;

    // Clamp a wide signed value into one data word; clip reports clamping
    function automatic data_t sat_word(input logic signed [63:0] x, output logic clip);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = 64'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
        lo = -64'((64'sd1 <<< (DATA_WIDTH - 1)));
        clip = 1'b0;
        if (x > hi) begin
            clip = 1'b1;
            return data_t'(hi);
        end else if (x < lo) begin
            clip = 1'b1;
            return data_t'(lo);
        end
        return data_t'(x);
    endfunction

endpackage

// File: rtl/dense_layer_sequencer_if.sv
// Vector handshake, weight ROM port and result bus of the dense layer sequencer.
interface dense_layer_sequencer_if #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned INPUT_SIZE  = 128,
    parameter int unsigned OUTPUT_SIZE = 16,
    parameter int unsigned ADDR_W      = $clog2(INPUT_SIZE * OUTPUT_SIZE)
);
    logic                                inValid;
    logic                                inReady;
    logic [INPUT_SIZE-1:0][WIDTH-1:0]    inputData;
    logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   biases;
    logic                                weightEn;
    logic [ADDR_W-1:0]                   weightAddr;
    logic [WIDTH-1:0]                    weightData;
    logic                                outValid;
    logic                                outReady;
    logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   outputData;
    logic                                satFlag;
    logic                                busy;

    modport master (
        output inValid, inputData, biases, weightData, outReady,
        input  inReady, weightEn, weightAddr, outValid, outputData, satFlag, busy
    );

    modport slave (
        input  inValid, inputData, biases, weightData, outReady,
        output inReady, weightEn, weightAddr, outValid, outputData, satFlag, busy
    );
endinterface

// File: rtl/dense_layer_sequencer_fixed_mac_sat.sv
// Single multiply-accumulate with clear, bias add, floor shift and saturation.
module fixed_mac_sat #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NFRAC      = 10,
    parameter int unsigned INPUT_SIZE = 128
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] bias,
    output logic [WIDTH-1:0]        res_c,
    output logic                    clip_c
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + $clog2(INPUT_SIZE) + 1;
    localparam int unsigned SW = AW + 1;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] shifted;
    logic [SW-1:0]        sum;
    logic                 pos_ovf;
    logic                 neg_ovf;

    assign prod = a * b;

    // Accumulator: cleared on a neuron's first MAC cycle, adds qualified products
    always_ff @(posedge clk) begin
        if (!resetN) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + {{(AW-PW){prod[PW-1]}}, prod};
        end
    end

    // Rescale (floor), add bias, clamp to one word
    always_comb begin
        shifted = acc_q >>> NFRAC;
        sum     = {shifted[AW-1], shifted} + {{(SW-WIDTH){bias[WIDTH-1]}}, bias};
        pos_ovf = !sum[SW-1] && (|sum[SW-2:WIDTH-1]);
        neg_ovf = sum[SW-1] && !(&sum[SW-2:WIDTH-1]);
        clip_c  = pos_ovf || neg_ovf;
        res_c   = sum[WIDTH-1:0];
        if (pos_ovf) res_c = {1'b0, {(WIDTH-1){1'b1}}};
        if (neg_ovf) res_c = {1'b1, {(WIDTH-1){1'b0}}};
    end
endmodule

// File: rtl/dense_layer_sequencer.sv
// Time-multiplexed fully-connected layer: one MAC walks every (output, input) pair.
module dense_layer_sequencer
    import data16_10::*;
#(
    parameter int unsigned WIDTH       = DATA_WIDTH,
    parameter int unsigned NFRAC       = DATA_NFRAC,
    parameter int unsigned INPUT_SIZE  = 128,
    parameter int unsigned OUTPUT_SIZE = 16,
    parameter int unsigned ADDR_W      = $clog2(INPUT_SIZE * OUTPUT_SIZE)
) (
    input  logic                    clk,
    input  logic                    resetN,
    dense_layer_sequencer_if.slave  bus
);
    localparam int unsigned IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int unsigned OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAC   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    state_t                            state_q, state_d;
    logic [IW-1:0]                     i_q, i_d, idx_q;
    logic [OW-1:0]                     o_q, o_d;
    logic [ADDR_W-1:0]                 addr_q, addr_d;
    logic                              wen_q, vld_q, in_ready_q, out_valid_q, busy_q, sat_q;
    logic                              capture, mac_clr, write_en;
    logic [INPUT_SIZE-1:0][WIDTH-1:0]  in_reg;
    logic [OUTPUT_SIZE-1:0][WIDTH-1:0] bias_reg;
    logic [OUTPUT_SIZE-1:0][WIDTH-1:0] out_q;
    logic [WIDTH-1:0]                  res_c;
    logic                              clip_c;

    // Next-state, counter and address sequencing
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        o_d      = o_q;
        addr_d   = addr_q;
        capture  = 1'b0;
        mac_clr  = 1'b0;
        write_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.inValid) begin
                    capture = 1'b1;
                    i_d     = '0;
                    o_d     = '0;
                    addr_d  = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                mac_clr = (i_q == '0);
                addr_d  = addr_q + ADDR_W'(1);
                if (i_q == IW'(INPUT_SIZE - 1)) state_d = S_DRAIN;
                else                            i_d = i_q + IW'(1);
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                write_en = 1'b1;
                if (o_q == OW'(OUTPUT_SIZE - 1)) begin
                    state_d = S_DONE;
                end else begin
                    o_d     = o_q + OW'(1);
                    i_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                if (bus.outReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered handshake/ROM outputs
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            o_q         <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            vld_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            o_q         <= o_d;
            idx_q       <= i_q;
            addr_q      <= addr_d;
            wen_q       <= (state_d == S_MAC);
            vld_q       <= wen_q;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Operand capture at accept
    always_ff @(posedge clk) begin
        if (capture) begin
            in_reg   <= bus.inputData;
            bias_reg <= bus.biases;
        end
    end

    // Result vector and sticky saturation flag
    always_ff @(posedge clk) begin
        if (!resetN) begin
            out_q <= '0;
            sat_q <= 1'b0;
        end else if (capture) begin
            sat_q <= 1'b0;
        end else if (write_en) begin
            out_q[o_q] <= res_c;
            sat_q      <= sat_q | clip_c;
        end
    end

    fixed_mac_sat #(
        .WIDTH      (WIDTH),
        .NFRAC      (NFRAC),
        .INPUT_SIZE (INPUT_SIZE)
    ) u_mac (
        .clk    (clk),
        .resetN (resetN),
        .clr    (mac_clr),
        .en     (vld_q),
        .a      (in_reg[idx_q]),
        .b      (bus.weightData),
        .bias   (bias_reg[o_q]),
        .res_c  (res_c),
        .clip_c (clip_c)
    );

    assign bus.inReady    = in_ready_q;
    assign bus.outValid   = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.weightEn   = wen_q;
    assign bus.weightAddr = addr_q;
    assign bus.outputData = out_q;
    assign bus.satFlag    = sat_q;
endmodule

// File: doc/dense_layer_sequencer.md
Name: dense_layer_sequencer

Overview:
Time-multiplexed controller for one fully-connected layer in the fixed-point inference pipeline. It accepts one input vector per transaction via valid/ready, then steps one MAC through every (output, input) pair. Weights come from an external synchronous weight ROM that it addresses. It adds the bias, saturates, and presents the finished output vector with valid/ready. It is the area-lean alternative to the fully parallel dense-latency layer, with the same array-style data ports.

Parameters:
WIDTH, 16, data word width (signed fixed point)
NFRAC, 10, fractional bits (Q6.10 default, matches data16_10 package)
INPUT_SIZE, 128, input vector length N
OUTPUT_SIZE, 16, output neurons O
ADDR_W, $clog2(INPUT_SIZE*OUTPUT_SIZE), weight ROM address width

Ports:
clk  in  1  clock; all logic on rising edge
resetN  in  1  synchronous, active-low reset
inValid  in  1  input vector and biases valid
inReady  out  1  block can accept a vector
inputData  in  WIDTH x INPUT_SIZE  signed input vector
biases  in  WIDTH x OUTPUT_SIZE  signed biases, sampled with inputData
weightEn  out  1  ROM read enable
weightAddr  out  ADDR_W  ROM address = o*INPUT_SIZE + i
weightData  in  WIDTH  signed weight, valid one cycle after weightEn
outValid  out  1  outputData complete
outReady  in  1  downstream accepts outputData
outputData  out  WIDTH x OUTPUT_SIZE  signed results, held registered
satFlag  out  1  at least one output saturated this transaction
busy  out  1  state != IDLE

Behaviour:
- Reset (resetN=0 at an edge), from any state including mid-MAC:
  - state IDLE; inReady=1; outValid=0; busy=0; weightEn=0; weightAddr=0.
  - outputData all 0; satFlag=0; accumulator and counters 0.
  - The current transaction is abandoned.
- States: IDLE, MAC, DRAIN, WRITE, DONE.
- IDLE:
  - inReady=1.
  - On inValid&&inReady: register inputData and biases, clear satFlag, set o=0, i=0, go to MAC.
- MAC (N cycles per neuron):
  - weightEn=1, weightAddr=o*N+i; i increments each cycle.
  - A one-cycle-delayed valid bit adds inReg[i-1]*weightData into the accumulator.
  - When i=N-1, go to DRAIN.
  - The accumulator clears on entry to each neuron's first MAC cycle.
- DRAIN (1 cycle): weightEn=0; accumulate the final product.
- WRITE (1 cycle):
  - res = (acc >>> NFRAC) + sign-extended bias[o], with arithmetic shift (truncation toward -inf).
  - Saturate res to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Clip sets satFlag (sticky until next accept).
  - outputData[o] <= res.
  - If o=O-1 go to DONE; else o++, i=0, go to MAC.
- Arithmetic widths:
  - product = 2*WIDTH bits.
  - accumulator = 2*WIDTH+$clog2(INPUT_SIZE)+1 bits; it never overflows internally.
  - Sum before saturation = accumulator width + 1.
- DONE:
  - outValid=1, inReady=0.
  - outputData and satFlag stay stable while outReady=0.
  - On outReady=1, go to IDLE at that edge (outValid falls next cycle).
- Latency: outValid is high after exactly O*(N+2) rising edges following the accepting edge.
- inValid is ignored outside IDLE. No overlap of transactions.
- weightData is sampled only in the cycle after a weightEn=1 cycle; all other values are don't-care.
- outputData elements not yet written in the current transaction keep their previous values. Only outValid qualifies the vector.

Decomposition:
- Package data16_10 holds: WIDTH/NFRAC constants, the data word typedef, a saturate-to-WIDTH function, and the state enum typedef.
- One natural sub-module, fixed_mac_sat: registered multiply-accumulate with clear, final bias add, and saturation with a clip flag.
- The sequencer FSM, counters and input/bias capture registers stay in the top block.

Test Plan:
(All with N=4, O=2, weight ROM model with 1-cycle latency.)
- Inputs all 0x0400 (1.0), weights all 0x0200 (0.5), biases 0x0100 -> both outputs 0x0900. satFlag=0. outValid exactly 12 edges after accept. weightAddr sequence 0,1,2,3,4,5,6,7.
- Inputs 0x4000, weights 0x4000, bias 0 -> outputs 0x7FFF, satFlag=1. Same inputs with weights 0xC000 -> 0x8000, satFlag=1.
- Truncation: input[0]=0x0001, weight[0]=0x0001, rest 0 -> out0=0x0000. Weight[0]=0xFFFF -> out0=0xFFFF (floor). Input -1.0 (0xFC00) x weights 0.5 -> 0xF800.
- Backpressure: hold outReady=0 for 10 cycles in DONE -> outValid, outputData, satFlag stable, inReady=0, inValid pulses ignored. Raise outReady -> IDLE next edge, inReady=1. Back-to-back second vector gives correct independent results with satFlag cleared.
- Reset mid-transaction: drive resetN=0 for one edge during the 3rd MAC cycle of neuron 1 -> all outputs at reset values next cycle. A following fresh transaction produces correct results with no residue from the accumulator.
